seg_scan_display: RTL and testbench

Parametrised multiplexed seven-segment driver; successor to the two-digit counter display. Accepts a binary value on a load strobe and converts it to BCD sequentially (shift-add-3, one bit per clock). Scans NUM_DIGITS digits with leading-zero blanking, per-digit blink and decimal point, overflow indication and tear-free display updates. Sits between the piano score/note logic and the board's common-anode/cathode display pins.

---
 rtl/seg_disp_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 68 ++++++
 rtl/seg_scan_display.sv | 140 ++++++++++++++
 tb/tb_seg_scan_display.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display.
// Segment vectors are ordered {g,f,e,d,c,b,a}, active-high.
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  typedef enum logic {SLOT_HOLD, SLOT_OPEN} scan_state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: seg_decode = SEG_DIGIT[0];
      4'd1: seg_decode = SEG_DIGIT[1];
      4'd2: seg_decode = SEG_DIGIT[2];
      4'd3: seg_decode = SEG_DIGIT[3];
      4'd4: seg_decode = SEG_DIGIT[4];
      4'd5: seg_decode = SEG_DIGIT[5];
      4'd6: seg_decode = SEG_DIGIT[6];
      4'd7: seg_decode = SEG_DIGIT[7];
      4'd8: seg_decode = SEG_DIGIT[8];
      4'd9: seg_decode = SEG_DIGIT[9];
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
// done and bcd are the final shift's result, so the caller can commit them on the edge busy falls.
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int VALUE_W    = 27,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    ovf
);

  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);

  logic                    busy_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic [VALUE_W-1:0]      sr_p0;
  logic [NUM_DIGITS*4-1:0] acc_p0;
  logic                    ovf_p0;
  logic [NUM_DIGITS*4-1:0] acc_adj;
  logic [NUM_DIGITS*4-1:0] acc_next;

  always_comb begin
    acc_adj = acc_p0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (acc_p0[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_p0[i*4 +: 4] + 4'd3;
    acc_next = {acc_adj[NUM_DIGITS*4-2:0], sr_p0[VALUE_W-1]};
  end

  // Control: busy spans exactly VALUE_W cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_p0 <= 1'b0;
      cnt_p0  <= '0;
    end else if (busy_p0) begin
      if (cnt_p0 == CNT_LAST) busy_p0 <= 1'b0;
      cnt_p0 <= cnt_p0 + 1'b1;
    end else if (start) begin
      busy_p0 <= 1'b1;
      cnt_p0  <= '0;
    end
  end

  // Datapath: capture on accepted start, then shift one bit per busy cycle
  always_ff @(posedge clk) begin
    if (start && !busy_p0) begin
      sr_p0  <= bin;
      acc_p0 <= '0;
      ovf_p0 <= 64'(bin) >= pow10(NUM_DIGITS);
    end else if (busy_p0) begin
      sr_p0  <= sr_p0 << 1;
      acc_p0 <= acc_next;
    end
  end

  assign busy = busy_p0;
  assign done = busy_p0 && (cnt_p0 == CNT_LAST);
  assign bcd  = acc_next;
  assign ovf  = ovf_p0;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: sequential BCD conversion, digit scanning with
// anti-ghost gap, leading-zero blanking, blink, decimal points and overflow dashes.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int VALUE_W        = 27,
  parameter int SCAN_DIV       = 10000,
  parameter int BLINK_DIV      = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  busy,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit_select
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  logic                    conv_done;
  logic                    conv_ovf;
  logic [NUM_DIGITS*4-1:0] conv_bcd;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (load),
    .bin   (value),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  logic [NUM_DIGITS*4-1:0] disp_p1;
  logic                    ovf_p1;

  // Display register: whole number and overflow swap in on one edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_p1 <= '0;
      ovf_p1  <= 1'b0;
    end else if (conv_done) begin
      disp_p1 <= conv_bcd;
      ovf_p1  <= conv_ovf;
    end
  end

  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      idx;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  blink_on;
  scan_state_t           state;
  logic                  tick;
  logic                  lead_zero;
  logic                  dark;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [6:0]            seg_p2;
  logic                  dp_p2;
  logic [NUM_DIGITS-1:0] sel_p2;

  assign tick = (scan_cnt == SCAN_LAST);

  always_comb begin
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(idx) && disp_p1[i*4 +: 4] != 4'd0) lead_zero = 1'b0;
    dark = blink_mask[idx] && !blink_on;
    if (dark)
      seg_nxt = SEG_BLANK;
    else if (ovf_p1)
      seg_nxt = SEG_DASH;
    else if (blank_lz && idx != '0 && lead_zero)
      seg_nxt = SEG_BLANK;
    else
      seg_nxt = seg_decode(disp_p1[{idx, 2'b00} +: 4]);
    dp_nxt = dp_mask[idx] && !dark;
  end

  // Output stage: gap on the tick edge, new digit on the following edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      state     <= SLOT_HOLD;
      seg_p2    <= '0;
      dp_p2     <= 1'b0;
      sel_p2    <= '0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      if (tick) begin
        state  <= SLOT_OPEN;
        sel_p2 <= '0;
        seg_p2 <= '0;
        dp_p2  <= 1'b0;
      end else if (state == SLOT_OPEN) begin
        state  <= SLOT_HOLD;
        sel_p2 <= NUM_DIGITS'(1) << idx;
        seg_p2 <= seg_nxt;
        dp_p2  <= dp_nxt;
        if (idx == IDX_LAST) begin
          idx <= '0;
          if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign overflow     = ovf_p1;
  assign seg          = seg_p2 ^ {7{SEG_INV}};
  assign dp           = dp_p2 ^ SEG_INV;
  assign digit_select = sel_p2 ^ {NUM_DIGITS{DIG_INV}};

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: 4 digits, 14-bit value, 4-cycle slots, 2-round blink.
module tb_seg_scan_display;

  localparam int N  = 4;
  localparam int VW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [N-1:0]  blink_mask = '0;
  logic [N-1:0]  dp_mask = '0;
  logic          busy;
  logic          overflow;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  digit_select;

  int vectors = 0;
  int errors  = 0;

  seg_scan_display #(
    .NUM_DIGITS(N), .VALUE_W(VW), .SCAN_DIV(4), .BLINK_DIV(2),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .busy(busy),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .dp_mask(dp_mask),
    .overflow(overflow), .seg(seg), .dp(dp), .digit_select(digit_select)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b0111111;
      1: pat = 7'b0000110;
      2: pat = 7'b1011011;
      3: pat = 7'b1001111;
      4: pat = 7'b1100110;
      5: pat = 7'b1101101;
      6: pat = 7'b1111101;
      7: pat = 7'b0000111;
      8: pat = 7'b1111111;
      9: pat = 7'b1101111;
      default: pat = 7'b0000000;
    endcase
  endfunction

  // Wait (bounded) for the start of a fresh slot of digit d, then sample it.
  task automatic grab(input int d, output logic [6:0] s, output logic p, output bit ok);
    logic [N-1:0] want;
    int n;
    want = N'(1) << d;
    n = 0;
    while (digit_select == want && n < 64) begin @(negedge clk); n++; end
    while (digit_select != want && n < 64) begin @(negedge clk); n++; end
    ok = (digit_select == want);
    s  = seg;
    p  = dp;
  endtask

  task automatic do_load(input logic [VW-1:0] v, output int bcycles);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bcycles = 0;
    while (busy && bcycles < 64) begin bcycles++; @(negedge clk); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k <= 4; k++) begin
      if (k == 1) rst_n = 1'b1;
      if (k > 0) @(negedge clk);
      vectors++;
      if ({digit_select, seg, dp, busy, overflow} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: sel=%b seg=%b dp=%b busy=%b ovf=%b, want all 0",
                 k, digit_select, seg, dp, busy, overflow);
      end
    end
    @(negedge clk);
    vectors++;
    if (digit_select !== 4'b0001 || seg !== 7'b0111111) begin
      errors++;
      $display("FAIL first_digit cycle 5: sel=%b seg=%b, want 0001 0111111", digit_select, seg);
    end
  endtask

  task automatic test_convert();
    int b;
    logic [6:0] s;
    logic p;
    bit ok;
    int exp_d [4] = '{4, 3, 2, 1};
    do_load(14'd1234, b);
    vectors++;
    if (b != 14) begin
      errors++;
      $display("FAIL busy_len_1234: got %0d cycles, want 14", b);
    end
    for (int d = 0; d < 4; d++) begin
      grab(d, s, p, ok);
      vectors++;
      if (!ok || s !== pat(exp_d[d])) begin
        errors++;
        $display("FAIL digit_1234[%0d]: seg=%b ok=%0b, want %b", d, s, ok, pat(exp_d[d]));
      end
    end
    grab(0, s, p, ok);
    while (digit_select == 4'b0001) @(negedge clk);
    vectors++;
    if (digit_select !== 4'b0000) begin
      errors++;
      $display("FAIL gap: sel=%b, want 0000", digit_select);
    end
    @(negedge clk);
    vectors++;
    if (digit_select !== 4'b0010) begin
      errors++;
      $display("FAIL after_gap: sel=%b, want 0010", digit_select);
    end
  endtask

  task automatic test_blank();
    int b;
    logic [6:0] s;
    logic p;
    bit ok;
    blank_lz = 1'b1;
    do_load(14'd7, b);
    for (int d = 0; d < 4; d++) begin
      grab(d, s, p, ok);
      vectors++;
      if (!ok || s !== ((d == 0) ? 7'b0000111 : 7'b0000000)) begin
        errors++;
        $display("FAIL blank_7[%0d]: seg=%b ok=%0b", d, s, ok);
      end
    end
    blank_lz = 1'b0;
    for (int d = 1; d < 4; d++) begin
      grab(d, s, p, ok);
      vectors++;
      if (!ok || s !== 7'b0111111) begin
        errors++;
        $display("FAIL noblank_7[%0d]: seg=%b ok=%0b, want 0111111", d, s, ok);
      end
    end
    blank_lz = 1'b1;
    do_load(14'd1005, b);
    grab(2, s, p, ok);
    vectors++;
    if (!ok || s !== 7'b0111111) begin
      errors++;
      $display("FAIL inner_zero_1005[2]: seg=%b ok=%0b, want 0111111", s, ok);
    end
    do_load(14'd0, b);
    grab(0, s, p, ok);
    vectors++;
    if (!ok || s !== 7'b0111111) begin
      errors++;
      $display("FAIL zero_digit0: seg=%b ok=%0b, want 0111111", s, ok);
    end
    grab(1, s, p, ok);
    vectors++;
    if (!ok || s !== 7'b0000000) begin
      errors++;
      $display("FAIL zero_digit1: seg=%b ok=%0b, want 0000000", s, ok);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_overflow();
    int b;
    logic [6:0] s;
    logic p;
    bit ok;
    logic last_busy_ovf;
    dp_mask  = 4'b0010;
    blank_lz = 1'b1;
    value = 14'd12000;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    last_busy_ovf = overflow;
    b = 0;
    while (busy && b < 64) begin last_busy_ovf = overflow; b++; @(negedge clk); end
    vectors++;
    if (last_busy_ovf !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_edge_12000: during=%b after=%b, want 0 then 1", last_busy_ovf, overflow);
    end
    for (int d = 0; d < 4; d++) begin
      grab(d, s, p, ok);
      vectors++;
      if (!ok || s !== 7'b1000000 || p !== (d == 1)) begin
        errors++;
        $display("FAIL dash[%0d]: seg=%b dp=%b ok=%0b, want 1000000 dp=%0d", d, s, p, ok, d == 1);
      end
    end
    value = 14'd42;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    last_busy_ovf = overflow;
    b = 0;
    while (busy && b < 64) begin last_busy_ovf = overflow; b++; @(negedge clk); end
    vectors++;
    if (last_busy_ovf !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_42: during=%b after=%b, want 1 then 0", last_busy_ovf, overflow);
    end
    grab(1, s, p, ok);
    vectors++;
    if (!ok || s !== pat(4) || p !== 1'b1) begin
      errors++;
      $display("FAIL digit_42[1]: seg=%b dp=%b ok=%0b, want %b dp=1", s, p, ok, pat(4));
    end
    do_load(14'd10000, b);
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_10000: got %b, want 1", overflow);
    end
    do_load(14'd9999, b);
    grab(3, s, p, ok);
    vectors++;
    if (overflow !== 1'b0 || !ok || s !== pat(9)) begin
      errors++;
      $display("FAIL ovf_9999: ovf=%b seg=%b ok=%0b, want 0 %b", overflow, s, ok, pat(9));
    end
    dp_mask  = 4'b0000;
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    int b;
    logic [6:0] s;
    logic p;
    bit ok;
    value = 14'd1234;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    b = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) b++;
      if (k == 3) begin value = 14'd9999; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (b != 14) begin
      errors++;
      $display("FAIL busy_ignore_load: got %0d busy cycles, want 14", b);
    end
    grab(0, s, p, ok);
    vectors++;
    if (!ok || s !== pat(4)) begin
      errors++;
      $display("FAIL keep_1234[0]: seg=%b ok=%0b, want %b", s, ok, pat(4));
    end
    grab(3, s, p, ok);
    vectors++;
    if (!ok || s !== pat(1)) begin
      errors++;
      $display("FAIL keep_1234[3]: seg=%b ok=%0b, want %b", s, ok, pat(1));
    end
  endtask

  task automatic test_blink();
    logic [6:0] s;
    logic p;
    bit ok;
    bit on;
    blink_mask = 4'b0001;
    dp_mask    = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      on = ((r / 2) % 2) == 0;
      grab(0, s, p, ok);
      vectors++;
      if (!ok || s !== (on ? 7'b0111111 : 7'b0000000) || p !== on) begin
        errors++;
        $display("FAIL blink_round%0d: seg=%b dp=%b ok=%0b, want lit=%0b", r, s, p, ok, on);
      end
      if (r == 2) begin
        grab(1, s, p, ok);
        vectors++;
        if (!ok || s !== 7'b0111111) begin
          errors++;
          $display("FAIL blink_unmasked: seg=%b ok=%0b, want 0111111", s, ok);
        end
      end
    end
    blink_mask = 4'b0000;
    dp_mask    = 4'b0000;
  endtask

  task automatic test_reset_midconv();
    int b;
    logic [6:0] s;
    logic p;
    bit ok;
    value = 14'd9876;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_cycle5: got %b, want 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b, want 0", busy);
    end
    grab(3, s, p, ok);
    vectors++;
    if (!ok || s !== 7'b0111111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cleared_display[3]: seg=%b busy=%b ok=%0b, want 0111111 busy=0", s, busy, ok);
    end
    do_load(14'd56, b);
    vectors++;
    if (b != 14) begin
      errors++;
      $display("FAIL busy_len_56: got %0d, want 14", b);
    end
    grab(0, s, p, ok);
    vectors++;
    if (!ok || s !== pat(6)) begin
      errors++;
      $display("FAIL digit_56[0]: seg=%b ok=%0b, want %b", s, ok, pat(6));
    end
    grab(1, s, p, ok);
    vectors++;
    if (!ok || s !== pat(5)) begin
      errors++;
      $display("FAIL digit_56[1]: seg=%b ok=%0b, want %b", s, ok, pat(5));
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_blank();
    test_overflow();
    test_back_to_back();
    test_blink();
    test_reset_midconv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
